// File: rtl/trig_pkg.sv
// trig_pkg: shared constants and types for the degree sine/cosine block.
//   TRIG_SCALE      fixed-point scale of the outputs (Q10; must stay 1024 so the
//                   consumer's z1*sin + z2*cos product sum fits in 32 bits)
//   TRIG_LUT_DEPTH  quarter-wave table entries (0..90 degrees)
//   ANGLE_W/OUT_W   input angle and output widths
//   RED_W           width of the reduced angle 0..359
//   LUT_AW/LUT_DW   quarter-wave ROM address / data widths
package trig_pkg;
  localparam int TRIG_SCALE     = 1024;
  localparam int TRIG_LUT_DEPTH = 91;
  localparam int ANGLE_W        = 32;
  localparam int OUT_W          = 32;
  localparam int RED_W          = 9;
  localparam int LUT_AW         = 7;
  localparam int LUT_DW         = 11;

  // Q0: 0..90, Q1: 91..180, Q2: 181..270, Q3: 271..359
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
endpackage

// File: rtl/sin_lut_q10.sv
// sin_lut_q10: combinational quarter-wave ROM, data = round(1024*sin(addr deg)),
// rounding half away from zero.
//   addr_i  7-bit angle 0..90 (out-of-range addresses read 0)
//   data_o  11-bit unsigned magnitude 0..1024
module sin_lut_q10
  import trig_pkg::*;
(
  input  logic [LUT_AW-1:0] addr_i,
  output logic [LUT_DW-1:0] data_o
);
  always_comb begin
    data_o = '0;
    case (addr_i)
      7'd0:  data_o = 11'd0;    7'd1:  data_o = 11'd18;   7'd2:  data_o = 11'd36;
      7'd3:  data_o = 11'd54;   7'd4:  data_o = 11'd71;   7'd5:  data_o = 11'd89;
      7'd6:  data_o = 11'd107;  7'd7:  data_o = 11'd125;  7'd8:  data_o = 11'd143;
      7'd9:  data_o = 11'd160;  7'd10: data_o = 11'd178;  7'd11: data_o = 11'd195;
      7'd12: data_o = 11'd213;  7'd13: data_o = 11'd230;  7'd14: data_o = 11'd248;
      7'd15: data_o = 11'd265;  7'd16: data_o = 11'd282;  7'd17: data_o = 11'd299;
      7'd18: data_o = 11'd316;  7'd19: data_o = 11'd333;  7'd20: data_o = 11'd350;
      7'd21: data_o = 11'd367;  7'd22: data_o = 11'd384;  7'd23: data_o = 11'd400;
      7'd24: data_o = 11'd416;  7'd25: data_o = 11'd433;  7'd26: data_o = 11'd449;
      7'd27: data_o = 11'd465;  7'd28: data_o = 11'd481;  7'd29: data_o = 11'd496;
      7'd30: data_o = 11'd512;  7'd31: data_o = 11'd527;  7'd32: data_o = 11'd543;
      7'd33: data_o = 11'd558;  7'd34: data_o = 11'd573;  7'd35: data_o = 11'd587;
      7'd36: data_o = 11'd602;  7'd37: data_o = 11'd616;  7'd38: data_o = 11'd630;
      7'd39: data_o = 11'd644;  7'd40: data_o = 11'd658;  7'd41: data_o = 11'd672;
      7'd42: data_o = 11'd685;  7'd43: data_o = 11'd698;  7'd44: data_o = 11'd711;
      7'd45: data_o = 11'd724;  7'd46: data_o = 11'd737;  7'd47: data_o = 11'd749;
      7'd48: data_o = 11'd761;  7'd49: data_o = 11'd773;  7'd50: data_o = 11'd784;
      7'd51: data_o = 11'd796;  7'd52: data_o = 11'd807;  7'd53: data_o = 11'd818;
      7'd54: data_o = 11'd828;  7'd55: data_o = 11'd839;  7'd56: data_o = 11'd849;
      7'd57: data_o = 11'd859;  7'd58: data_o = 11'd868;  7'd59: data_o = 11'd878;
      7'd60: data_o = 11'd887;  7'd61: data_o = 11'd896;  7'd62: data_o = 11'd904;
      7'd63: data_o = 11'd912;  7'd64: data_o = 11'd920;  7'd65: data_o = 11'd928;
      7'd66: data_o = 11'd935;  7'd67: data_o = 11'd943;  7'd68: data_o = 11'd949;
      7'd69: data_o = 11'd956;  7'd70: data_o = 11'd962;  7'd71: data_o = 11'd968;
      7'd72: data_o = 11'd974;  7'd73: data_o = 11'd979;  7'd74: data_o = 11'd984;
      7'd75: data_o = 11'd989;  7'd76: data_o = 11'd994;  7'd77: data_o = 11'd998;
      7'd78: data_o = 11'd1002; 7'd79: data_o = 11'd1005; 7'd80: data_o = 11'd1008;
      7'd81: data_o = 11'd1011; 7'd82: data_o = 11'd1014; 7'd83: data_o = 11'd1016;
      7'd84: data_o = 11'd1018; 7'd85: data_o = 11'd1020; 7'd86: data_o = 11'd1022;
      7'd87: data_o = 11'd1023; 7'd88: data_o = 11'd1023; 7'd89: data_o = 11'd1024;
      7'd90: data_o = 11'd1024;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/trigonometry_deg.sv
// trigonometry_deg: two-stage pipeline computing round(1024*cos) and
// round(1024*sin) of an integer angle in degrees.
//   i_clock  rising-edge clock
//   i_RESET  asynchronous active-low reset (outputs forced to cos=1024, sin=0)
//   i_theta  signed 32-bit angle, any value
//   o_cos    signed 32-bit, registered, two edges after i_theta is sampled
//   o_sin    signed 32-bit, registered, two edges after i_theta is sampled
// Stage 1 reduces the angle mod 360 and decodes the quadrant; stage 2 folds
// into the quarter-wave table and applies the sign.
module trigonometry_deg
  import trig_pkg::*;
(
  input  logic                      i_clock,
  input  logic                      i_RESET,
  input  logic signed [ANGLE_W-1:0] i_theta,
  output logic signed [OUT_W-1:0]   o_cos,
  output logic signed [OUT_W-1:0]   o_sin
);
  // ---------------- stage 1: mod-360 reduction ----------------
  // The raw 32 bits are folded byte-wise using 2^8, 2^16, 2^24 mod 360 =
  // 256, 16, 136. A negative input is u - 2^32, and -2^32 = +104 (mod 360),
  // so the sign bit just adds 104. The sum is at most 104399 (17 bits).
  logic [16:0]      fold_sum;
  logic [8:0]       fold_quo;
  logic [RED_W-1:0] r_d, r_q;
  quad_e            quad_d, quad_q;

  always_comb begin
    fold_sum = 17'(i_theta[31:24]) * 17'd136
             + 17'(i_theta[23:16]) * 17'd16
             + {1'b0, i_theta[15:8], 8'd0}
             + 17'(i_theta[7:0])
             + (i_theta[31] ? 17'd104 : 17'd0);
    // floor(fold_sum/360) by reciprocal multiply: 186414/2^26 overshoots
    // 1/360 by < 0.00076 over the whole fold_sum range, below the 1/360
    // margin, so the floor is exact without a divider.
    fold_quo = 9'((35'(fold_sum) * 35'd186414) >> 26);
    r_d      = 9'(fold_sum - 17'(fold_quo) * 17'd360);
    if      (r_d <= 9'd90)  quad_d = Q0;
    else if (r_d <= 9'd180) quad_d = Q1;
    else if (r_d <= 9'd270) quad_d = Q2;
    else                    quad_d = Q3;
  end

  // ---------------- stage 2: fold, lookup, sign ----------------
  logic [LUT_AW-1:0] sin_addr, cos_addr;
  logic [LUT_DW-1:0] sin_mag, cos_mag;
  logic              sin_neg, cos_neg;
  logic [OUT_W-1:0]  sin_ext, cos_ext, sin_d, cos_d, sin_q, cos_q;

  always_comb begin
    sin_addr = 7'(r_q);
    cos_addr = 7'(9'd90 - r_q);
    sin_neg  = 1'b0;
    cos_neg  = 1'b0;
    case (quad_q)
      Q0: begin
        sin_addr = 7'(r_q);
        cos_addr = 7'(9'd90 - r_q);
      end
      Q1: begin
        sin_addr = 7'(9'd180 - r_q);
        cos_addr = 7'(r_q - 9'd90);
        cos_neg  = 1'b1;
      end
      Q2: begin
        sin_addr = 7'(r_q - 9'd180);
        cos_addr = 7'(9'd270 - r_q);
        sin_neg  = 1'b1;
        cos_neg  = 1'b1;
      end
      Q3: begin
        sin_addr = 7'(9'd360 - r_q);
        cos_addr = 7'(r_q - 9'd270);
        sin_neg  = 1'b1;
      end
      default: ;
    endcase
  end

  sin_lut_q10 u_lut_sin (.addr_i(sin_addr), .data_o(sin_mag));
  sin_lut_q10 u_lut_cos (.addr_i(cos_addr), .data_o(cos_mag));

  // Two's-complement negation of 0 is 0, so no negative zero can appear.
  always_comb begin
    sin_ext = {{(OUT_W-LUT_DW){1'b0}}, sin_mag};
    cos_ext = {{(OUT_W-LUT_DW){1'b0}}, cos_mag};
    sin_d   = sin_neg ? -sin_ext : sin_ext;
    cos_d   = cos_neg ? -cos_ext : cos_ext;
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      r_q    <= '0;
      quad_q <= Q0;
      sin_q  <= '0;
      cos_q  <= OUT_W'(TRIG_SCALE);
    end else begin
      r_q    <= r_d;
      quad_q <= quad_d;
      sin_q  <= sin_d;
      cos_q  <= cos_d;
    end
  end

  assign o_sin = sin_q;
  assign o_cos = cos_q;
endmodule

// File: tb/tb_trigonometry_deg.sv
module tb_trigonometry_deg;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [31:0] theta = 32'sd45;
  logic signed [31:0] o_cos, o_sin;

  int n_cmp = 0;
  int n_err = 0;

  trigonometry_deg dut (
    .i_clock(clk), .i_RESET(rst_n), .i_theta(theta),
    .o_cos(o_cos), .o_sin(o_sin)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic void model(input logic signed [31:0] th, output int c, output int s);
    longint r;
    real a;
    r = longint'(th) % 360;
    if (r < 0) r = r + 360;
    a = real'(r) * 3.14159265358979323846 / 180.0;
    c = rnd(1024.0 * $cos(a));
    s = rnd(1024.0 * $sin(a));
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, req, $time);
    end
  endtask

  // Angles seen by the DUT at the last two edges, and edges since reset release.
  logic signed [31:0] th_p1, th_p2;
  int edges = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges <= 0;
    end else begin
      th_p1 <= theta;
      th_p2 <= th_p1;
      edges <= (edges < 2) ? edges + 1 : 2;
    end
  end

  // Continuous compare on every falling edge.
  always @(negedge clk) begin
    int ec, es;
    if (edges >= 2) model(th_p2, ec, es);
    else begin ec = 1024; es = 0; end
    chk("stream_cos", int'(o_cos), ec);
    chk("stream_sin", int'(o_sin), es);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Hand-computed vectors: theta, cos, sin
  int tv_th[15]  = '{45, 0, 90, 180, 270, -90, 450, 720, -1, 2147483647,
                     30, -2147483647-1, 91, 271, -360};
  int tv_cos[15] = '{724, 1024, 0, -1024, 0, 0, 0, 1024, 1024, -616,
                     887, -630, -18, 18, 1024};
  int tv_sin[15] = '{724, 0, 1024, 0, -1024, -1024, 1024, 0, -18, 818,
                     512, -807, 1024, -1024, 0};

  initial begin
    // Reset held with theta = 45.
    theta = 32'sd45;
    rst_n = 1'b0;
    repeat (3) begin
      step();
      chk("reset_cos", int'(o_cos), 1024);
      chk("reset_sin", int'(o_sin), 0);
    end
    rst_n = 1'b1;
    step();
    chk("rel1_cos", int'(o_cos), 1024);
    chk("rel1_sin", int'(o_sin), 0);
    step();
    chk("rel2_cos", int'(o_cos), 724);
    chk("rel2_sin", int'(o_sin), 724);

    // Directed literals, each held two edges.
    for (int i = 0; i < 15; i++) begin
      theta = tv_th[i];
      step();
      step();
      chk($sformatf("dir%0d_cos(%0d)", i, tv_th[i]), int'(o_cos), tv_cos[i]);
      chk($sformatf("dir%0d_sin(%0d)", i, tv_th[i]), int'(o_sin), tv_sin[i]);
    end

    // Ramp 0..359 one per cycle; the stream checker covers every sample.
    for (int k = 0; k < 360; k++) begin
      theta = k;
      step();
    end
    step();
    step();
    chk("ramp_end_cos", int'(o_cos), 1024);
    chk("ramp_end_sin", int'(o_sin), -18);

    // Ramp with a short reset pulse in the middle.
    for (int k = 0; k < 40; k++) begin
      theta = 1000 + k;
      if (k == 20) begin
        rst_n = 1'b0;
        #1;
        chk("pulse_cos", int'(o_cos), 1024);
        chk("pulse_sin", int'(o_sin), 0);
        #1;
        rst_n = 1'b1;
      end
      step();
    end
    // Negative ramp around the wrap point.
    for (int k = -400; k < -300; k++) begin
      theta = k;
      step();
    end
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end
endmodule

// File: doc/trigonometry_deg.md
# trigonometry_deg

Computes sine and cosine of an integer angle in degrees as signed fixed-point values scaled by 1024. It feeds the hybrid controller's half-plane jump test (jump = z1·sin + z2·cos), where only the sign of that result is used. It is a two-stage pipeline that accepts a new angle every cycle.

## Interface
- No parameters. Scale (1024), table depth (91) and widths are package constants.
- i_clock  input  1  system clock; all registers update on the rising edge.
- i_RESET  input  1  reset, asynchronous, active-low: 0 = reset asserted.
- i_theta  input  32 signed  angle in whole degrees; any 32-bit value is legal.
- o_cos  output  32 signed  round(1024·cos θ), registered.
- o_sin  output  32 signed  round(1024·sin θ), registered.

## Operation
- Reduction: r = θ mod 360, in the range 0..359. Negative inputs wrap upward: −90 → 270, −360 → 0, −1 → 359.
- Quarter-wave table: T[k] = round(1024·sin k°) for k = 0..90, rounding half away from zero.
  - T[0] = 0, T[30] = 512, T[45] = 724, T[60] = 887, T[90] = 1024.
- Quadrant folding:
  - 0..90: sin = T[r], cos = T[90−r]
  - 91..180: sin = T[180−r], cos = −T[r−90]
  - 181..270: sin = −T[r−180], cos = −T[270−r]
  - 271..359: sin = −T[360−r], cos = T[r−270]
- Exact axis values follow from the folding: sin 90 = 1024, cos 90 = 0, cos 180 = −1024, sin 270 = −1024. Zero is never output as a negative value.
- Output magnitude is at most 1024, sign-extended to 32 bits. The bits above bit 11 always equal the sign bit.
- Consumer width rule: with |z1| ≤ 1,016,426 and |z2| ≤ 737,190, z1·sin + z2·cos stays below 2^31. The 1024 scale must not be increased.
- No handshake. Every cycle is a valid sample.

## Timing
- Stage 1 registers r (9 bits) and the 2-bit quadrant. The mod-360 of the full 32-bit input must close timing at the system clock.
- Stage 2 registers o_sin and o_cos from the table lookup and negation.
- Latency: an angle applied before rising edge n appears on the outputs after edge n+1, i.e. two edges.
- Throughput: one angle per cycle. Back-to-back changes pass through in order, with no bubbles.
- While i_RESET = 0, asynchronously and immediately:
  - stage-1 angle = 0, quadrant = 0
  - o_cos = 1024, o_sin = 0
- After reset is released, the first edge loads stage 1 and the second edge produces a real output.
- Reset asserted mid-stream discards all in-flight angles.
- If i_theta is held constant, the outputs are constant from the second edge onward.

## Structure
- Package trig_pkg:
  - TRIG_SCALE = 1024
  - TRIG_LUT_DEPTH = 91
  - ANGLE_W = 32, OUT_W = 32, RED_W = 9
  - the quadrant enum Q0..Q3
- Sub-module sin_lut_q10: combinational 91-entry ROM, address 0..90, 11-bit unsigned data.
  - Instantiated twice in trigonometry_deg, once for the sine address and once for the cosine address.
- Top level: mod-360 reducer, quadrant decoder, address generation, sign application, pipeline registers.

## Test plan
- Reset: hold i_RESET = 0 with i_theta = 45 → o_cos = 1024, o_sin = 0 throughout. Release reset → (724, 724) after the second edge.
- Cardinal angles: 0, 90, 180, 270 → (cos, sin) = (1024, 0), (0, 1024), (−1024, 0), (0, −1024), each two edges after applying.
- Wrap-around: −90, 450, 720, −1, 2147483647 → sin = −1024, 1024, 0, −18, and the sin of 2147483647 mod 360 (= 127°) = 818.
- Table accuracy: sweep 0..359 and compare each result to round(1024·sin) / round(1024·cos); the error must be 0 LSB.
- Pipeline streaming: ramp i_theta 0, 1, 2, … one step per cycle → outputs follow the same ramp exactly two edges later, with no dropped or repeated samples.
- Mid-stream reset: pulse i_RESET low for less than one cycle during the ramp → outputs jump to (1024, 0) immediately, then resume with the current angle two edges after release.
